// File: rtl/spi_vector_tx.sv
// SPI mode-0 master: sends an 8-bit command and then up to PAYLOAD_W payload bits, MSB first.
// Define SPI_TX_MISO_EN to add i_miso capture into rx_data.
module spi_vector_tx #(
  parameter int PAYLOAD_W = 72,
  parameter int SCLK_DIV  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     cmd,
  input  logic [PAYLOAD_W-1:0]           payload,
  input  logic [$clog2(PAYLOAD_W+1)-1:0] len,
  output logic                           o_sclk,
  output logic                           o_mosi,
  output logic                           o_ss_n,
  output logic                           busy,
  output logic                           done
`ifdef SPI_TX_MISO_EN
  ,
  input  logic                           i_miso,
  output logic [7:0]                     rx_data
`endif
);

  localparam int LEN_W    = $clog2(PAYLOAD_W + 1);
  localparam int HALF_MAX = (SCLK_DIV > GAP_CYC) ? SCLK_DIV : GAP_CYC;
  localparam int HALF_W   = $clog2(HALF_MAX + 1);
  localparam int BIT_W    = $clog2(PAYLOAD_W + 9);
  localparam int SR_W     = PAYLOAD_W + 8;

  localparam logic [HALF_W-1:0] HALF_D  = HALF_W'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_G  = HALF_W'(GAP_CYC - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(PAYLOAD_W);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [HALF_W-1:0] half_cnt, half_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [SR_W-1:0]   sr, sr_nxt;
  logic              sclk_nxt, mosi_nxt, ss_n_nxt, busy_nxt, done_nxt;

  logic [LEN_W-1:0]  len_c;
  logic [SR_W-1:0]   frame;

  // The payload is left-aligned so that payload[len-1] follows cmd[0] directly.
  assign len_c = (len > LEN_MAX) ? LEN_MAX : len;
  assign frame = {cmd, payload << (LEN_MAX - len_c)};

`ifdef SPI_TX_MISO_EN
  logic [7:0] rx_nxt;
`endif

  always_comb begin
    state_nxt = state;
    half_nxt  = half_cnt;
    bit_nxt   = bit_cnt;
    sr_nxt    = sr;
    sclk_nxt  = o_sclk;
    mosi_nxt  = o_mosi;
    ss_n_nxt  = o_ss_n;
    busy_nxt  = busy;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT_LO;
          half_nxt  = HALF_D;
          bit_nxt   = BIT_W'(len_c) + BIT_W'(8);
          // sr holds the bits still to be sent after the one now on o_mosi.
          sr_nxt    = {frame[SR_W-2:0], 1'b0};
          sclk_nxt  = 1'b0;
          mosi_nxt  = cmd[7];
          ss_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (half_cnt == '0) begin
          state_nxt = SHIFT_HI;
          half_nxt  = HALF_D;
          sclk_nxt  = 1'b1;
        end else begin
          half_nxt = half_cnt - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (half_cnt == '0) begin
          half_nxt = HALF_D;
          sclk_nxt = 1'b0;
          if (bit_cnt > BIT_W'(1)) begin
            state_nxt = SHIFT_LO;
            bit_nxt   = bit_cnt - 1'b1;
            mosi_nxt  = sr[SR_W-1];
            sr_nxt    = {sr[SR_W-2:0], 1'b0};
          end else begin
            state_nxt = HOLD;
          end
        end else begin
          half_nxt = half_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (half_cnt == '0) begin
          state_nxt = GAP;
          half_nxt  = HALF_G;
          ss_n_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
        end else begin
          half_nxt = half_cnt - 1'b1;
        end
      end
      GAP: begin
        if (half_cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          half_nxt = half_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // done is registered, so it is raised one cycle early: when the next cycle is the final GAP cycle.
    done_nxt = (state_nxt == GAP) && (half_nxt == '0);

`ifdef SPI_TX_MISO_EN
    rx_nxt = rx_data;
    if (sclk_nxt && !o_sclk) rx_nxt = {rx_data[6:0], i_miso};
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
      o_ss_n   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_TX_MISO_EN
      rx_data  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      half_cnt <= half_nxt;
      bit_cnt  <= bit_nxt;
      sr       <= sr_nxt;
      o_sclk   <= sclk_nxt;
      o_mosi   <= mosi_nxt;
      o_ss_n   <= ss_n_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
`ifdef SPI_TX_MISO_EN
      rx_data  <= rx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_spi_vector_tx.sv
// Self-checking bench for spi_vector_tx: an SPI receiver model captures bits on each o_sclk rise,
// and the result is compared against the frame rules computed arithmetically from cmd, payload and len.
module tb_spi_vector_tx;

  localparam int PW = 72;
  localparam int D  = 2;
  localparam int G  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cmd;
  logic [71:0] payload;
  logic [6:0]  len;
  logic        o_sclk, o_mosi, o_ss_n, busy, done;

  int n_pass  = 0;
  int n_total = 0;

`ifdef SPI_TX_MISO_EN
  logic       i_miso = 1'b0;
  logic [7:0] rx_data;
  logic [7:0] miso_pat = 8'hC3;
  int         miso_idx = 0;
  logic       miso_prev = 1'b0;

  // MISO model: returns miso_pat MSB-first on the last 8 rising edges of a 16-bit frame.
  always @(negedge clk) begin
    if (o_ss_n) miso_idx = 0;
    else if (o_sclk && !miso_prev) miso_idx = miso_idx + 1;
    miso_prev = o_sclk;
    i_miso = (miso_idx >= 8 && miso_idx < 16) ? miso_pat[15 - miso_idx] : miso_idx[0];
  end
`endif

  spi_vector_tx #(.PAYLOAD_W(PW), .SCLK_DIV(D), .GAP_CYC(G)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cmd     (cmd),
    .payload (payload),
    .len     (len),
    .o_sclk  (o_sclk),
    .o_mosi  (o_mosi),
    .o_ss_n  (o_ss_n),
    .busy    (busy),
    .done    (done)
`ifdef SPI_TX_MISO_EN
    ,
    .i_miso  (i_miso),
    .rx_data (rx_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    cmd = '0; payload = '0; len = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({o_ss_n, o_sclk, o_mosi, busy, done} !== 5'b10000)
        $display("FAIL reset_outputs cycle %0d: got ss_n/sclk/mosi/busy/done=%b expected 10000",
                 i, {o_ss_n, o_sclk, o_mosi, busy, done});
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  // Sends one frame and compares everything the receiver model observed with the expected frame.
  task automatic frame_scenario(input string name, input logic [7:0] c, input logic [71:0] p,
                                input logic [6:0] l, input bit mid_start);
    logic [79:0] exp_bits, got_bits;
    int le, exp_n, exp_busy, got_n, busy_cyc, ss_low, done_cnt, done_at, unstable;
    logic prev_sclk, prev_mosi;
    logic [95:0] r;

    le       = (int'(l) > PW) ? PW : int'(l);
    exp_n    = 8 + le;
    exp_bits = ({72'b0, c} << le) | ({8'b0, p} & ((80'd1 << le) - 80'd1));
    exp_busy = exp_n * 2 * D + D + G;

    @(negedge clk);
    cmd = c; payload = p; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r = {$urandom, $urandom, $urandom};
    cmd = r[7:0]; payload = r[71:0]; len = r[94:88];

    got_bits = '0; got_n = 0; busy_cyc = 0; ss_low = 0; done_cnt = 0; done_at = -1; unstable = 0;
    prev_sclk = 1'b0; prev_mosi = o_mosi;
    while (busy === 1'b1 && busy_cyc < 2000) begin
      busy_cyc++;
      if (o_ss_n === 1'b0) ss_low++;
      if (done === 1'b1) begin done_cnt++; done_at = busy_cyc; end
      if (o_sclk && !prev_sclk) begin
        got_bits = {got_bits[78:0], o_mosi};
        got_n++;
        if (o_mosi !== prev_mosi) unstable++;
      end else if (o_sclk && prev_sclk && o_mosi !== prev_mosi) begin
        unstable++;
      end
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
      start = mid_start && (busy_cyc == 40);
      @(negedge clk);
    end
    start = 1'b0;

    n_total++;
    if (got_n !== exp_n) $display("FAIL %s bit_count: got %0d expected %0d", name, got_n, exp_n);
    else n_pass++;
    n_total++;
    if (got_bits !== exp_bits) $display("FAIL %s bits: got %h expected %h", name, got_bits, exp_bits);
    else n_pass++;
    n_total++;
    if (busy_cyc !== exp_busy) $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, exp_busy);
    else n_pass++;
    n_total++;
    if (ss_low !== exp_n * 2 * D + D)
      $display("FAIL %s ss_low_cycles: got %0d expected %0d", name, ss_low, exp_n * 2 * D + D);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || done_at !== exp_busy)
      $display("FAIL %s done_pulse: got count %0d at cycle %0d expected 1 at %0d", name, done_cnt, done_at, exp_busy);
    else n_pass++;
    n_total++;
    if (unstable !== 0) $display("FAIL %s mosi_stable: got %0d changes expected 0", name, unstable);
    else n_pass++;
    n_total++;
    if ({o_ss_n, o_sclk, done} !== 3'b100)
      $display("FAIL %s idle_after: got ss_n/sclk/done=%b expected 100", name, {o_ss_n, o_sclk, done});
    else n_pass++;
  endtask

  task automatic test_cmd_only();
    frame_scenario("cmd_only", 8'hA5, 72'h0, 7'd0, 1'b0);
  endtask

  task automatic test_full_frame();
    frame_scenario("full_frame", 8'h03, 72'h123456789ABCDEF012, 7'd72, 1'b0);
  endtask

  task automatic test_clamp_busy();
    frame_scenario("clamp_len100", 8'h5C, 72'hFEDCBA9876543210AB, 7'd100, 1'b1);
  endtask

  task automatic test_random();
    logic [95:0] r;
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom};
      frame_scenario($sformatf("random%0d", i), r[95:88], r[71:0], 7'($urandom_range(0, 90)), 1'b0);
    end
  endtask

  task automatic test_abort();
    int rises, cyc, done_seen, busy_seen;
    logic prev_sclk;
    @(negedge clk);
    cmd = 8'hFF; payload = {72{1'b1}}; len = 7'd72; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; cyc = 0; prev_sclk = 1'b0;
    while (rises < 20 && cyc < 500) begin
      if (o_sclk && !prev_sclk) rises++;
      prev_sclk = o_sclk;
      cyc++;
      if (rises < 20) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if (rises !== 20 || {o_ss_n, o_sclk, o_mosi, busy, done} !== 5'b10000)
      $display("FAIL abort_idle: got rises=%0d ss_n/sclk/mosi/busy/done=%b expected 20 and 10000",
               rises, {o_ss_n, o_sclk, o_mosi, busy, done});
    else n_pass++;
    done_seen = 0; busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    n_total++;
    if (done_seen !== 0 || busy_seen !== 0)
      $display("FAIL abort_no_done: got done=%0d busy=%0d cycles expected 0 and 0", done_seen, busy_seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int falls, hi_run, cyc, done_cnt;
    int gaps[2];
    logic prev_ss;
    cmd = 8'h96; payload = 72'hA; len = 7'd4; start = 1'b1;
    falls = 0; hi_run = 0; cyc = 0; done_cnt = 0; prev_ss = 1'b1;
    gaps[0] = -1; gaps[1] = -1;
    while (falls < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (o_ss_n === 1'b1) hi_run++;
      else begin
        if (prev_ss) begin
          if (falls > 0) gaps[falls-1] = hi_run;
          falls++;
        end
        hi_run = 0;
      end
      prev_ss = o_ss_n;
    end
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) done_cnt++;
    end
    n_total++;
    if (falls !== 3) $display("FAIL b2b_frames: got %0d expected 3", falls);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (gaps[i] !== G + 1) $display("FAIL b2b_gap%0d: got %0d expected %0d", i, gaps[i], G + 1);
      else n_pass++;
    end
    n_total++;
    if (done_cnt !== 3) $display("FAIL b2b_done_count: got %0d expected 3", done_cnt);
    else n_pass++;
  endtask

`ifdef SPI_TX_MISO_EN
  task automatic test_miso();
    int cyc;
    @(negedge clk);
    cmd = 8'h3C; payload = 72'h5A; len = 7'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (done !== 1'b1 || rx_data !== 8'hC3)
      $display("FAIL miso_rx_data: got done=%b rx=%h expected 1 and c3", done, rx_data);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (rx_data !== 8'hC3) $display("FAIL miso_rx_hold: got %h expected c3", rx_data);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_only();
    test_full_frame();
    test_clamp_busy();
    test_random();
    test_abort();
    test_back_to_back();
`ifdef SPI_TX_MISO_EN
    test_miso();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_vector_tx.md
Name: spi_vector_tx

Overview:
SPI mode-0 master. Serializes an 8-bit command byte followed by a variable-length payload onto sclk/mosi/ss_n. It drives the raybox SPI receiver (i_sclk/i_mosi/i_ss_n) from on-board logic, for example a button or test-pattern driven position/vector updater, so the Pico link is not needed. Frames are MSB-first, and ss_n brackets exactly one frame.

Parameters:
PAYLOAD_W, 72, maximum payload bits per frame (e.g. 6 x 12-bit vectors)
SCLK_DIV, 2, clk cycles per SCLK half-period (D); legal range >= 1
GAP_CYC, 4, minimum clk cycles ss_n is held high after a frame, before done; legal range >= 1

Ports:
clk  in  1  system clock (25 MHz pixel clock domain)
reset  in  1  synchronous, active-high reset
start  in  1  request a frame; sampled only in IDLE
cmd  in  8  command byte; sent first
payload  in  PAYLOAD_W  payload bits; payload[len-1] is sent first, payload[0] last
len  in  $clog2(PAYLOAD_W+1)  payload bit count, 0..PAYLOAD_W
o_sclk  out  1  SPI clock; idles low
o_mosi  out  1  SPI data; changes only while o_sclk is low
o_ss_n  out  1  active-low select
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse at frame completion

Behaviour:
- Reset value of every output: o_sclk=0, o_mosi=0, o_ss_n=1, busy=0, done=0. Reset takes effect at the next clk edge from any state and aborts any frame in flight. No done pulse is produced for an aborted frame.
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP.
- IDLE: start=1 is accepted. cmd, payload and min(len, PAYLOAD_W) are latched. N = 8 + latched len. On the next cycle:
  - state=SHIFT_LO, busy=1, o_ss_n=0, o_sclk=0, o_mosi=cmd[7].
- SHIFT_LO: o_sclk=0 for D cycles, then go to SHIFT_HI.
- SHIFT_HI: o_sclk=1 for D cycles. The receiver samples o_mosi on the rising edge. At the end of the phase:
  - if bits remain, go to SHIFT_LO and present the next bit on o_mosi;
  - otherwise go to HOLD.
- Bit order: cmd[7]..cmd[0], then payload[len-1]..payload[0].
- HOLD: o_sclk=0 and o_ss_n=0 for D cycles. o_mosi holds the last bit. Then go to GAP.
- GAP: o_ss_n=1, o_mosi=0 for GAP_CYC cycles. On the final GAP cycle done=1. The next cycle has busy=0 and state IDLE.
- Busy duration: exactly N*2*D + D + GAP_CYC cycles.
- start while busy: ignored, not queued. Inputs may change freely after acceptance.
- start held high continuously: a new frame is accepted on the first IDLE cycle. Back-to-back frames are therefore separated by GAP_CYC + 1 cycles of ss_n high.
- len > PAYLOAD_W: clamped to PAYLOAD_W. len=0: command-only frame, N=8.
- Counters:
  - half-period counter width $clog2(max(SCLK_DIV, GAP_CYC)+1);
  - bit counter width $clog2(PAYLOAD_W+9).
  - Neither counter wraps; each reloads on every state entry.
- All outputs are registered (no combinational path from inputs to o_*).

Optional Feature:
SPI_TX_MISO_EN
- Defined:
  - Adds input i_miso (1 bit) and output rx_data (8 bits, reset 0).
  - i_miso is sampled on the clk edge where o_sclk transitions 0->1 and shifted into rx_data LSB-first-in (i.e. left shift).
  - rx_data holds the last 8 sampled bits and is stable from the done pulse until the next accepted start. Frames shorter than 8 bits cannot occur.
  - The i_miso input must be pre-synchronised by the instantiator.
- Undefined: neither port exists and there is no capture logic. The remaining behaviour is identical.

Test Plan:
- Reset state: assert reset for 3 cycles -> o_ss_n=1, o_sclk=0, o_mosi=0, busy=0, done=0 on every cycle.
- Command-only frame: D=2, GAP_CYC=4, start with cmd=8'hA5, len=0 -> 8 rising edges carrying 1,0,1,0,0,1,0,1. Busy for 8*4+2+4=38 cycles, done is a single pulse on the last of them.
- Full frame: len=72, payload=72'h123456789ABCDEF012, cmd=8'h03 -> receiver model captures 80 bits equal to {8'h03, payload}. o_mosi is stable for the whole o_sclk=1 phase. ss_n stays low for 80*4+2 cycles.
- Clamp and busy behaviour: len=100 -> 72 payload bits sent. A start pulse mid-frame -> ignored, and frame length is unchanged.
- Abort and back-to-back: reset asserted at bit 20 -> next cycle shows the idle outputs and no done pulse. Then start held high for 3 frames -> each frame is separated by 5 cycles of ss_n high.
- MISO readback (SPI_TX_MISO_EN): i_miso model returns 8'hC3 during the last 8 bits -> rx_data=8'hC3 at done.
